poly_red_pipe: RTL and testbench
================================

POLY_RED_PIPE -- requirements
Module: poly_red_pipe

Interface
REQ-001 SHALL have parameter CpaBits, default 16, meaning carry-propagate segment width.
REQ-002 SHALL have parameter CpaCoeffs, default 2*NumCoeffs*WordBits/CpaBits, meaning number of CPA segments.
REQ-003 SHALL have parameter useCPA [CpaCoeffs-1:0], default 0, meaning per-segment CPA-product select.
REQ-004 SHALL have parameter PipeDepth, default 2, legal 1..4, meaning result register stages.
REQ-005 SHALL have parameter TagBits, default 4, meaning sideband tag width.
REQ-006 clk_i  in  1  clock; rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 in_valid_i  in  1  operand valid; in_ready_o  out  1  operand accepted when both high.
REQ-008 mul_product0_i, mul_product1_i  in  NumBits2x each  redundant multiplier product.
REQ-009 mul_cpa_product_i  in  CpaCoeffs x (CpaBits+1)  segmented CPA product.
REQ-010 byp_i, x_i  in  poly_t  bypass operand, external operand.
REQ-011 mode_i  in  red_mode_e  RED_MUL / RED_BYP / RED_X.
REQ-012 tag_i  in  TagBits; tag_o  out  TagBits  sideband tag carried with data.
REQ-013 flush_i  in  1  synchronous pipeline discard.
REQ-014 out_valid_o  out  1; out_ready_i  in  1  output handshake.
REQ-015 mul_o, byp_o  out  poly_t  result pair; busy_o  out  1  any stage occupied.

Function
REQ-016 Reduced value SHALL come from one combinational poly_reduce (ForSquare=0) on the current inputs.
REQ-017 On accept: mul result = byp_i if RED_BYP, else reduced; byp result = x_i if RED_X, else mul result.
REQ-018 Each of PipeDepth stages SHALL hold valid, mul, byp, tag; stage k loads when empty or when stage k+1 accepts (bubble-collapsing).
REQ-019 in_ready_o SHALL be high iff stage 0 empty or stage 0 advances this cycle, and low while flush_i is high.
REQ-020 The last stage SHALL drive out_valid_o, mul_o, byp_o, tag_o; it advances on out_valid_o && out_ready_i.
REQ-021 Latency: exactly PipeDepth cycles accept-to-out_valid_o with no backpressure; throughput 1 per cycle.
REQ-022 While out_valid_o && !out_ready_i, mul_o, byp_o and tag_o SHALL be held stable; no operand is lost or duplicated.
REQ-023 Capacity SHALL be PipeDepth operands; with out_ready_i low, in_ready_o drops after PipeDepth accepts.
REQ-024 Simultaneous output pop and input accept with full pipeline SHALL be accepted the same cycle.
REQ-025 flush_i SHALL clear all stage valids at the next edge; data registers keep values; an input in the flush cycle is dropped.
REQ-026 Flush has priority over accept and pop in the same cycle.
REQ-027 busy_o = OR of all stage valids.
REQ-028 Data registers of empty stages SHALL not load (no toggling on idle cycles).

Reset
REQ-029 On rst_ni low, all stage valids, mul_o, byp_o, tag_o SHALL go to 0 immediately; out_valid_o=0, busy_o=0.
REQ-030 in_ready_o SHALL be 1 in the first cycle after reset release; reset mid-operation discards all in-flight operands.

Structure
REQ-031 red_mode_e (2-bit enum) SHALL be added to mrt_pkg; poly_t, NumBits2x, NumCoeffs, WordBits stay there.
REQ-032 Stages SHALL be a generate loop in this module; the single sub-module is poly_reduce.
REQ-033 A non-synthesis checker SHALL compare the de-Montgomeryised reduced value with the table-driven sum of the inputs mod Modulus on every accept.

Verification
REQ-034 PipeDepth=2, RED_MUL, product0=1, product1=0, tag=3 accepted cycle 0 -> out_valid_o cycle 2, tag_o=3, mul_o equals model reduction of 1.
REQ-035 RED_BYP byp_i=0x1234, x_i=0x55 -> mul_o=byp_o=0x1234; RED_X same inputs -> byp_o=0x55, mul_o=reduced product.
REQ-036 out_ready_i low, 5 back-to-back valids, PipeDepth=2 -> exactly 2 accepted, outputs stable; release -> tags emerge in order, none lost.
REQ-037 Full pipe, out_ready_i=1 and in_valid_i=1 continuously 20 cycles -> 20 accepts, 20 pops, in order.
REQ-038 flush_i with 2 operands in flight and in_valid_i=1 -> next cycle busy_o=0, out_valid_o=0, no output of flushed tags.
REQ-039 rst_ni low mid-stream -> outputs 0 asynchronously; after release first accepted operand emerges after PipeDepth cycles.

Source files
------------

// File: rtl/mrt_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | mrt_pkg                                                        |
// | Shared ring parameters, polynomial word type and the reducer  |
// | output-mode encoding.                                          |
// | Revision: 1.1                                                  |
// +----------------------------------------------------------------+
package mrt_pkg;

  localparam int WordBits   = 16;
  localparam int NumCoeffs  = 2;
  localparam int NumBits2x  = 2 * NumCoeffs * WordBits;
  // Prime modulus 2^16 - 15 and -Modulus^-1 mod 2^WordBits for Montgomery REDC.
  localparam int Modulus    = 65521;
  localparam int MontNPrime = 61167;

  typedef logic [NumCoeffs*WordBits-1:0] poly_t;

  typedef enum logic [1:0] {
    RED_MUL = 2'd0,
    RED_BYP = 2'd1,
    RED_X   = 2'd2
  } red_mode_e;

endpackage
`default_nettype wire

// File: rtl/poly_red_pipe_reduce.sv
`default_nettype none
// +----------------------------------------------------------------+
// | poly_reduce                                                    |
// | Resolves the redundant / segmented multiplier product into one |
// | value per coefficient lane and Montgomery-reduces each lane.  |
// | Revision: 1.1                                                  |
// +----------------------------------------------------------------+
module poly_reduce import mrt_pkg::*; #(
  parameter int                   CpaBits   = 16,
  parameter int                   CpaCoeffs = NumBits2x / CpaBits,
  parameter logic [CpaCoeffs-1:0] useCPA    = '0,
  parameter bit                   ForSquare = 1'b0
) (
  input  logic [NumBits2x-1:0]          product0_i,
  input  logic [NumBits2x-1:0]          product1_i,
  input  logic [CpaCoeffs-1:0][CpaBits:0] cpa_product_i,
  output poly_t                         reduced_o
);

  localparam int LaneBits    = 2 * WordBits;
  localparam int SegsPerLane = LaneBits / CpaBits;
  localparam int QBits       = WordBits + 2;
  localparam logic [QBits-1:0]      ModQ   = QBits'(Modulus);
  localparam logic [LaneBits+1:0]   ModL   = (LaneBits+2)'(Modulus);
  localparam logic [WordBits-1:0]   NPrime = WordBits'(MontNPrime);

  logic [NumBits2x-1:0] prod;

  // Segment-wise carry chain; the carry restarts at each lane and the lane carry-out is dropped.
  always_comb begin
    logic              carry;
    logic [CpaBits:0]  seg_sum;
    logic [CpaBits-1:0] op1;
    prod    = '0;
    carry   = 1'b0;
    seg_sum = '0;
    op1     = '0;
    for (int s = 0; s < CpaCoeffs; s++) begin
      if (s % SegsPerLane == 0) carry = 1'b0;
      op1 = ForSquare ? '0 : product1_i[s*CpaBits +: CpaBits];
      if (useCPA[s]) begin
        seg_sum = cpa_product_i[s] + {{CpaBits{1'b0}}, carry};
      end else begin
        seg_sum = {1'b0, product0_i[s*CpaBits +: CpaBits]} + {1'b0, op1}
                + {{CpaBits{1'b0}}, carry};
      end
      prod[s*CpaBits +: CpaBits] = seg_sum[CpaBits-1:0];
      carry = seg_sum[CpaBits];
    end
  end

  // REDC per lane: q = (T + m*N) / R can reach 2N+14, so two conditional subtractions.
  for (genvar c = 0; c < NumCoeffs; c++) begin : g_lane
    logic [LaneBits-1:0] t_lane;
    logic [WordBits-1:0] m;
    logic [QBits-1:0]    q;
    logic [QBits-1:0]    q1;

    assign t_lane = prod[c*LaneBits +: LaneBits];
    assign m      = t_lane[WordBits-1:0] * NPrime;
    assign q      = QBits'(({2'b00, t_lane} + (LaneBits+2)'(m) * ModL) >> WordBits);
    assign q1     = (q >= ModQ) ? q - ModQ : q;
    assign reduced_o[c*WordBits +: WordBits] = WordBits'((q1 >= ModQ) ? q1 - ModQ : q1);
  end

endmodule
`default_nettype wire

// File: rtl/poly_red_pipe.sv
`default_nettype none
// +----------------------------------------------------------------+
// | poly_red_pipe                                                  |
// | Reduces a multiplier product, selects mul/byp results and     |
// | carries them with a tag through a bubble-collapsing pipeline. |
// | Revision: 1.1                                                  |
// +----------------------------------------------------------------+
module poly_red_pipe import mrt_pkg::*; #(
  parameter int                   CpaBits   = 16,
  parameter int                   CpaCoeffs = 2 * NumCoeffs * WordBits / CpaBits,
  parameter logic [CpaCoeffs-1:0] useCPA    = '0,
  parameter int                   PipeDepth = 2,
  parameter int                   TagBits   = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic [NumBits2x-1:0]            mul_product0_i,
  input  logic [NumBits2x-1:0]            mul_product1_i,
  input  logic [CpaCoeffs-1:0][CpaBits:0] mul_cpa_product_i,
  input  poly_t                           byp_i,
  input  poly_t                           x_i,
  input  red_mode_e                       mode_i,
  input  logic [TagBits-1:0]              tag_i,
  input  logic                            flush_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output poly_t                           mul_o,
  output poly_t                           byp_o,
  output logic [TagBits-1:0]              tag_o,
  output logic                            busy_o
);

  localparam int LaneBits = 2 * WordBits;

  poly_t                reduced;
  poly_t                acc_mul;
  poly_t                acc_byp;
  logic [PipeDepth-1:0] stage_valid;

  poly_reduce #(
    .CpaBits   (CpaBits),
    .CpaCoeffs (CpaCoeffs),
    .useCPA    (useCPA),
    .ForSquare (1'b0)
  ) u_reduce (
    .product0_i    (mul_product0_i),
    .product1_i    (mul_product1_i),
    .cpa_product_i (mul_cpa_product_i),
    .reduced_o     (reduced)
  );

  assign acc_mul = (mode_i == RED_BYP) ? byp_i : reduced;
  assign acc_byp = (mode_i == RED_X)   ? x_i   : acc_mul;

  for (genvar k = 0; k < PipeDepth; k++) begin : g_stage
    logic               valid_q;
    logic               valid_d;
    logic               ready;
    logic               leave;
    logic               load;
    logic               in_vld;
    poly_t              in_mul;
    poly_t              in_byp;
    logic [TagBits-1:0] in_tag;
    poly_t              mul_q;
    poly_t              byp_q;
    logic [TagBits-1:0] tag_q;

    if (k == 0) begin : g_head
      assign in_vld = in_valid_i;
      assign in_mul = acc_mul;
      assign in_byp = acc_byp;
      assign in_tag = tag_i;
    end else begin : g_body
      assign in_vld = g_stage[k-1].valid_q;
      assign in_mul = g_stage[k-1].mul_q;
      assign in_byp = g_stage[k-1].byp_q;
      assign in_tag = g_stage[k-1].tag_q;
    end

    if (k == PipeDepth - 1) begin : g_tail
      assign leave = valid_q & out_ready_i;
    end else begin : g_mid
      assign leave = valid_q & g_stage[k+1].ready;
    end

    // A stage can take new contents when empty or when its current contents move on.
    assign ready   = ~valid_q | leave;
    assign valid_d = flush_i ? 1'b0 : (ready ? in_vld : valid_q);
    assign load    = ~flush_i & ready & in_vld;
    assign stage_valid[k] = valid_q;

    // Occupancy flag for this stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) valid_q <= 1'b0;
      else         valid_q <= valid_d;
    end

    // Payload only moves when a real operand arrives, so idle stages stay quiet.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        mul_q <= '0;
        byp_q <= '0;
        tag_q <= '0;
      end else if (load) begin
        mul_q <= in_mul;
        byp_q <= in_byp;
        tag_q <= in_tag;
      end
    end
  end

  assign in_ready_o  = g_stage[0].ready & ~flush_i;
  assign out_valid_o = g_stage[PipeDepth-1].valid_q;
  assign mul_o       = g_stage[PipeDepth-1].mul_q;
  assign byp_o       = g_stage[PipeDepth-1].byp_q;
  assign tag_o       = g_stage[PipeDepth-1].tag_q;
  assign busy_o      = |stage_valid;

`ifndef SYNTHESIS
  localparam logic [63:0] ModW  = 64'(Modulus);
  localparam logic [63:0] RModN = (64'd1 << WordBits) % ModW;

  function automatic logic redc_ok(input logic [LaneBits-1:0] t,
                                   input logic [WordBits-1:0] r);
    logic [63:0] lhs;
    logic [63:0] rhs;
    lhs = (64'(r) * RModN) % ModW;
    rhs = ((64'(t) >> WordBits) * RModN + 64'(t[WordBits-1:0])) % ModW;
    return lhs == rhs;
  endfunction

  // Every accepted reduction, mapped back out of Montgomery form, must equal the lane sum mod Modulus.
  always_ff @(posedge clk_i) begin
    if (rst_ni && in_valid_i && in_ready_o && (useCPA == '0)) begin
      for (int c = 0; c < NumCoeffs; c++) begin
        assert (redc_ok(LaneBits'(mul_product0_i[c*LaneBits +: LaneBits]
                                + mul_product1_i[c*LaneBits +: LaneBits]),
                        reduced[c*WordBits +: WordBits]));
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_poly_red_pipe.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_poly_red_pipe                                               |
// | Directed bench for poly_red_pipe with PipeDepth=2.             |
// | Revision: 1.1                                                  |
// +----------------------------------------------------------------+
module tb_poly_red_pipe;
  import mrt_pkg::*;

  logic              clk_i;
  logic              rst_ni;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [NumBits2x-1:0] p0;
  logic [NumBits2x-1:0] p1;
  logic [3:0][16:0]  cpa;
  poly_t             byp_i;
  poly_t             x_i;
  red_mode_e         mode_i;
  logic [3:0]        tag_i;
  logic              flush_i;
  logic              out_valid_o;
  logic              out_ready_i;
  poly_t             mul_o;
  poly_t             byp_o;
  logic [3:0]        tag_o;
  logic              busy_o;

  typedef struct packed {
    logic [3:0] tag;
    poly_t      mul;
    poly_t      byp;
  } exp_t;

  exp_t       sb[$];
  poly_t      exp_mul;
  poly_t      exp_byp;
  logic [3:0] nxt_tag;
  logic [3:0] f_tag;
  int         n_cmp;
  int         n_fail;
  int         accs;
  int         pops;
  int         a_start;
  int         p_start;
  bit         last_acc;

  poly_red_pipe #(
    .PipeDepth (2),
    .TagBits   (4)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .in_valid_i        (in_valid_i),
    .in_ready_o        (in_ready_o),
    .mul_product0_i    (p0),
    .mul_product1_i    (p1),
    .mul_cpa_product_i (cpa),
    .byp_i             (byp_i),
    .x_i               (x_i),
    .mode_i            (mode_i),
    .tag_i             (tag_i),
    .flush_i           (flush_i),
    .out_valid_o       (out_valid_o),
    .out_ready_i       (out_ready_i),
    .mul_o             (mul_o),
    .byp_o             (byp_o),
    .tag_o             (tag_o),
    .busy_o            (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // One clock: settle, score any pop against the queue, record any accept, then advance.
  task automatic cycle();
    exp_t e;
    #1;
    last_acc = 1'b0;
    if (out_valid_o && out_ready_i) begin
      pops++;
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL pop_unexpected observed_tag=%0h expected=none", tag_o);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pop_tag", 64'(tag_o), 64'(e.tag));
        check("pop_mul", 64'(mul_o), 64'(e.mul));
        check("pop_byp", 64'(byp_o), 64'(e.byp));
      end
    end
    if (in_valid_i && in_ready_o) begin
      accs++;
      last_acc = 1'b1;
      e.tag = tag_i;
      e.mul = exp_mul;
      e.byp = exp_byp;
      sb.push_back(e);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_byp_op();
    tag_i   = nxt_tag;
    byp_i   = 32'hB000_0000 | 32'(nxt_tag);
    exp_mul = byp_i;
    exp_byp = byp_i;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; accs = 0; pops = 0; last_acc = 1'b0;
    rst_ni = 1'b0; in_valid_i = 1'b0; p0 = '0; p1 = '0; cpa = '0;
    byp_i = '0; x_i = '0; mode_i = RED_MUL; tag_i = '0; flush_i = 1'b0;
    out_ready_i = 1'b1; exp_mul = '0; exp_byp = '0; nxt_tag = 4'd4; f_tag = '0;
    a_start = 0; p_start = 0;

    // Reset state
    #2;
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_mul", 64'(mul_o), 64'd0);
    check("rst_byp", 64'(byp_o), 64'd0);
    check("rst_tag", 64'(tag_o), 64'd0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_ni = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready_o), 64'd1);

    // Latency: REDC(1) = 2^-16 mod 65521 = 0xEEE1 in lane 0, lane 1 is 0
    mode_i = RED_MUL; p0 = 64'd1; p1 = 64'd0; tag_i = 4'd3; in_valid_i = 1'b1;
    exp_mul = 32'h0000_EEE1; exp_byp = 32'h0000_EEE1;
    cycle();
    in_valid_i = 1'b0;
    check("t1_cycle1_valid", 64'(out_valid_o), 64'd0);
    cycle();
    check("t1_cycle2_valid", 64'(out_valid_o), 64'd1);
    check("t1_tag", 64'(tag_o), 64'd3);
    check("t1_mul", 64'(mul_o), 64'h0000_EEE1);
    cycle();
    check("t1_drained", 64'(out_valid_o), 64'd0);

    // Mode select: lane0 T=10+5=15 -> 1, lane1 T=1 -> 0xEEE1
    mode_i = RED_BYP; byp_i = 32'h1234; x_i = 32'h55;
    p0 = 64'h0000_0001_0000_000A; p1 = 64'd5; tag_i = 4'd1; in_valid_i = 1'b1;
    exp_mul = 32'h1234; exp_byp = 32'h1234;
    cycle();
    mode_i = RED_X; tag_i = 4'd2; exp_mul = 32'hEEE1_0001; exp_byp = 32'h55;
    cycle();
    in_valid_i = 1'b0;
    check("t2_byp_mul", 64'(mul_o), 64'h1234);
    check("t2_byp_byp", 64'(byp_o), 64'h1234);
    cycle();
    check("t2_x_mul", 64'(mul_o), 64'hEEE1_0001);
    check("t2_x_byp", 64'(byp_o), 64'h55);
    check("t2_x_tag", 64'(tag_o), 64'd2);
    cycle();
    check("t2_drained", 64'(out_valid_o), 64'd0);

    // Backpressure: 5 offered, capacity 2, head held stable
    out_ready_i = 1'b0; mode_i = RED_BYP; x_i = '0; a_start = accs;
    for (int i = 0; i < 5; i++) begin
      set_byp_op();
      in_valid_i = 1'b1;
      cycle();
      if (last_acc) nxt_tag++;
    end
    check("t3_accepts", 64'(accs - a_start), 64'd2);
    check("t3_valid", 64'(out_valid_o), 64'd1);
    check("t3_hold_tag", 64'(tag_o), 64'd4);
    check("t3_hold_mul", 64'(mul_o), 64'hB000_0004);
    #1;
    check("t3_in_ready", 64'(in_ready_o), 64'd0);
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    cycle();
    cycle();
    check("t3_drained", 64'(out_valid_o), 64'd0);
    check("t3_sb_empty", 64'(sb.size()), 64'd0);

    // Full pipe streaming: pop and accept together for 20 cycles
    out_ready_i = 1'b0; in_valid_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_byp_op();
      cycle();
      if (last_acc) nxt_tag++;
    end
    out_ready_i = 1'b1; a_start = accs; p_start = pops;
    for (int i = 0; i < 20; i++) begin
      set_byp_op();
      cycle();
      if (last_acc) nxt_tag++;
    end
    check("t4_accepts", 64'(accs - a_start), 64'd20);
    check("t4_pops", 64'(pops - p_start), 64'd20);
    in_valid_i = 1'b0;
    cycle();
    cycle();
    check("t4_drained", 64'(out_valid_o), 64'd0);
    check("t4_sb_empty", 64'(sb.size()), 64'd0);

    // Flush with two in flight and a new input offered
    out_ready_i = 1'b0; in_valid_i = 1'b1; f_tag = nxt_tag;
    for (int i = 0; i < 2; i++) begin
      set_byp_op();
      cycle();
      if (last_acc) nxt_tag++;
    end
    set_byp_op();
    flush_i = 1'b1;
    #1;
    check("t5_in_ready_flush", 64'(in_ready_o), 64'd0);
    cycle();
    flush_i = 1'b0; in_valid_i = 1'b0;
    check("t5_busy", 64'(busy_o), 64'd0);
    check("t5_out_valid", 64'(out_valid_o), 64'd0);
    check("t5_data_kept", 64'(mul_o), 64'(32'hB000_0000 | 32'(f_tag)));
    sb.delete();
    out_ready_i = 1'b1;
    cycle();
    check("t5_no_output", 64'(out_valid_o), 64'd0);
    cycle();
    check("t5_still_idle", 64'(busy_o), 64'd0);

    // Asynchronous reset mid-stream
    out_ready_i = 1'b0; in_valid_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_byp_op();
      cycle();
      if (last_acc) nxt_tag++;
    end
    in_valid_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    check("t6_rst_valid", 64'(out_valid_o), 64'd0);
    check("t6_rst_busy", 64'(busy_o), 64'd0);
    check("t6_rst_mul", 64'(mul_o), 64'd0);
    check("t6_rst_byp", 64'(byp_o), 64'd0);
    check("t6_rst_tag", 64'(tag_o), 64'd0);
    sb.delete();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    // Lane0 0xFFFF+1 = 2^16 -> REDC = 1 (carry crosses segment boundary)
    mode_i = RED_MUL; p0 = 64'h0000_FFFF; p1 = 64'd1; tag_i = 4'hC;
    exp_mul = 32'h1; exp_byp = 32'h1; in_valid_i = 1'b1; out_ready_i = 1'b1;
    #1;
    check("t6_in_ready", 64'(in_ready_o), 64'd1);
    cycle();
    in_valid_i = 1'b0;
    check("t6_cycle1_valid", 64'(out_valid_o), 64'd0);
    cycle();
    check("t6_cycle2_valid", 64'(out_valid_o), 64'd1);
    check("t6_tag", 64'(tag_o), 64'hC);
    check("t6_mul", 64'(mul_o), 64'h1);
    cycle();
    check("t6_drained", 64'(out_valid_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
